// File: rtl/pipe_pkg.sv
// Shared types and constants for the RISC-V inter-stage pipeline registers:
// stage occupancy encoding, control-bundle bit positions and per-stage widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } stage_state_e;

  // Bit positions inside the control bundle; multi-bit fields give their LSB.
  localparam int CTRL_RF_WE   = 0;
  localparam int CTRL_DRAM_WE = 1;
  localparam int CTRL_PC_SEL  = 2;
  localparam int CTRL_WD_SEL  = 4;
  localparam int CTRL_ALU_OP  = 6;

  localparam int IF_ID_CTRL_W   = 16;
  localparam int IF_ID_DATA_W   = 64;
  localparam int ID_EX_CTRL_W   = 16;
  localparam int ID_EX_DATA_W   = 128;
  localparam int EX_MEM_CTRL_W  = 16;
  localparam int EX_MEM_DATA_W  = 96;
  localparam int MEM_WB_CTRL_W  = 16;
  localparam int MEM_WB_DATA_W  = 64;

  typedef struct packed {
    logic       rf_we;
    logic       dram_we;
    logic [1:0] pc_sel;
    logic [1:0] wd_sel;
    logic [3:0] alu_op;
  } ctrl_fields_t;

  function automatic ctrl_fields_t ctrl_decode(input logic [15:0] c);
    ctrl_fields_t f;
    f.rf_we   = c[CTRL_RF_WE];
    f.dram_we = c[CTRL_DRAM_WE];
    f.pc_sel  = c[CTRL_PC_SEL +: 2];
    f.wd_sel  = c[CTRL_WD_SEL +: 2];
    f.alu_op  = c[CTRL_ALU_OP +: 4];
    return f;
  endfunction

endpackage

// File: rtl/pipe_stage_stat.sv
// Saturating 32-bit event counters (stall cycles, effective flushes) for a
// pipeline stage; only instantiated when PIPE_STAGE_STAT_EN is defined.
module pipe_stage_stat (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [1:0]  w_evt;
  logic [31:0] r_cnt [2];

  assign w_evt = {flush_evt, stall_evt};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_cnt[gi] <= '0;
        else if (w_evt[gi] && (r_cnt[gi] != 32'hFFFF_FFFF))
          r_cnt[gi] <= r_cnt[gi] + 32'd1;
      end
    end
  endgenerate

  assign stall_cnt = r_cnt[0];
  assign flush_cnt = r_cnt[1];

endmodule

// File: rtl/pipe_stage_rv.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer, flush and
// bubble-safe control. Optional counters under PIPE_STAGE_STAT_EN.
module pipe_stage_rv import pipe_pkg::*; #(
  parameter int                CTRL_W      = ID_EX_CTRL_W,
  parameter int                DATA_W      = ID_EX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STAT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  stage_state_e      r_state, w_next;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;

  logic w_accept, w_drain;
  logic w_ld_main_in, w_ld_main_skid, w_ld_skid;
  logic w_bubble_main, w_bubble_skid;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = r_in_ready;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign w_accept  = in_valid & r_in_ready;
  assign w_drain   = out_valid & out_ready;

  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_bubble_main  = 1'b0;
    w_bubble_skid  = 1'b0;
    if (flush) begin
      w_next        = EMPTY;
      w_bubble_main = 1'b1;
      w_bubble_skid = 1'b1;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          w_next       = FULL;
          w_ld_main_in = 1'b1;
        end
        FULL: begin
          if (w_accept && w_drain) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_ld_skid = 1'b1;
            w_next    = SKID;
          end else if (w_drain) begin
            w_bubble_main = 1'b1;
            w_next        = EMPTY;
          end
        end
        SKID: if (w_drain) begin
          w_ld_main_skid = 1'b1;
          w_next         = FULL;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  // Data flops load only on a real transfer; ctrl flops also take the bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_ctrl <= CTRL_BUBBLE;
      r_main_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != SKID);
      if (w_bubble_main) begin
        r_main_ctrl <= CTRL_BUBBLE;
      end else if (w_ld_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_bubble_skid) begin
        r_skid_ctrl <= CTRL_BUBBLE;
      end else if (w_ld_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STAT_EN
  pipe_stage_stat u_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_evt (out_valid & ~out_ready & ~flush),
    .flush_evt (flush & (r_state != EMPTY)),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Self-checking bench for pipe_stage_rv against a 2-deep FIFO reference model;
// the counter scenario runs when PIPE_STAGE_STAT_EN is defined.
module tb_pipe_stage_rv;

  localparam int CW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STAT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: entries held by the stage, oldest first, at most two.
  logic [CW+DW-1:0] mq[$];

  always #5 clk = ~clk;

  pipe_stage_rv #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  function automatic logic [CW+DW+1:0] expv();
    logic [CW+DW+1:0] e;
    e = '0;
    e[CW+DW+1] = (mq.size() < 2);
    if (mq.size() > 0) e[CW+DW:0] = {1'b1, mq[0]};
    return e;
  endfunction

  function automatic logic [CW+DW+1:0] obs();
    return {in_ready, out_valid, out_ctrl, out_valid ? out_data : {DW{1'b0}}};
  endfunction

  // One clock: drive at negedge, update the model at posedge, settle by #1.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    logic acc, drn;
    @(negedge clk);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    acc = v && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({c, d});
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (obs() !== {1'b1, 1'b0, {CW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++; $display("FAIL reset got %h required %h", obs(), {1'b1, {CW+DW+1{1'b0}}});
    end
  endtask

  task automatic test_single();
    step(1'b1, 16'h0003, 128'hA5, 1'b1, 1'b0);
    n_tests++;
    if (!(out_valid === 1'b1 && out_ctrl === 16'h0003 && out_data === 128'hA5)) begin
      n_fail++; $display("FAIL single_out got v=%b c=%h d=%h required v=1 c=0003 d=a5", out_valid, out_ctrl, out_data);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_tests++;
    if (!(out_valid === 1'b0 && out_ctrl === 16'h0000)) begin
      n_fail++; $display("FAIL single_bubble got v=%b c=%h required v=0 c=0000", out_valid, out_ctrl);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, CW'(i * 3), DW'(i), 1'b1, 1'b0);
      n_tests++;
      if (!(out_valid === 1'b1 && out_data === DW'(i) && in_ready === 1'b1) || obs() !== expv()) begin
        n_fail++; $display("FAIL stream[%0d] got %h required %h", i, obs(), expv());
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_tests++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL stream_end got %h required %h", obs(), expv());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] seen[$];
    step(1'b1, 16'h0011, 128'd1, 1'b0, 1'b0);
    step(1'b1, 16'h0012, 128'd2, 1'b0, 1'b0);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready got %b required 0", in_ready);
    end
    step(1'b1, 16'h0013, 128'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (out_valid === 1'b1) seen.push_back(out_data);
      step(i < 2, 16'h0013, 128'd3, 1'b1, 1'b0);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL bp_step[%0d] got %h required %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (seen.size() != 3 || seen[0] !== 128'd1 || seen[1] !== 128'd2 || seen[2] !== 128'd3) begin
      n_fail++; $display("FAIL bp_order got %0d entries required 1,2,3", seen.size());
    end
  endtask

  task automatic test_flush();
    step(1'b1, 16'h0105, 128'd5, 1'b0, 1'b0);
    step(1'b1, 16'h0106, 128'd6, 1'b0, 1'b0);
    step(1'b1, 16'h0107, 128'd7, 1'b0, 1'b1);
    n_tests++;
    if (!(out_valid === 1'b0 && out_ctrl === 16'h0000 && in_ready === 1'b1)) begin
      n_fail++; $display("FAIL flush got v=%b c=%h r=%b required v=0 c=0000 r=1", out_valid, out_ctrl, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0 || obs() !== expv()) begin
        n_fail++; $display("FAIL flush_after[%0d] got %h required %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, CW'($urandom), d,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random[%0d] got %h required %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h00FF, 128'h1234, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!(out_valid === 1'b0 && out_ctrl === 16'h0000 && in_ready === 1'b1)) begin
      n_fail++; $display("FAIL async_reset got v=%b c=%h r=%b required v=0 c=0000 r=1", out_valid, out_ctrl, in_ready);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef PIPE_STAGE_STAT_EN
  task automatic test_stats();
    do_reset();
    step(1'b1, 16'h0001, 128'h77, 1'b0, 1'b0);
    repeat (10) step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    n_tests++;
    if (stall_cnt !== 32'd10) begin
      n_fail++; $display("FAIL stat_stall got %0d required 10", stall_cnt);
    end
    n_tests++;
    if (flush_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stat_flush got %0d required 1", flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
`ifdef PIPE_STAGE_STAT_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_rv.md
Name: pipe_stage_rv

Overview:
- Generic elastic pipeline stage register that replaces the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a parametrised control bundle and data bundle with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Control bits are forced to a safe value whenever the stage holds a bubble, so downstream write enables can never fire spuriously.
- Sits between any two pipeline stages of the RISC-V core; the hazard unit drives flush and backpressure drives out_ready.

Parameters:
- CTRL_W, 16, width of the control bundle (rf_we, dram_we, pc_sel, wd_sel, alu_op, ...).
- DATA_W, 128, width of the data bundle (pc, sext, rD1, rD2, alu_b, ...).
- CTRL_BUBBLE, 0, value driven on out_ctrl and loaded into control storage for a bubble or flush.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries; highest priority.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; driven directly by a flop.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main control; equals CTRL_BUBBLE whenever out_valid=0.
- out_data  out  DATA_W  main data; don't-care when out_valid=0.
- stall_cnt  out  32  present only with PIPE_STAGE_STAT_EN.
- flush_cnt  out  32  present only with PIPE_STAGE_STAT_EN.

Behaviour:
- Reset:
  - Clock is clk; reset rst_n is asynchronous, active-low.
  - On reset: state=EMPTY, out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE, out_data=0, skid storage ctrl=CTRL_BUBBLE and data=0, counters=0.
  - Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Storage: a main entry (drives the outputs) plus one skid entry.
- States and transitions:
  - EMPTY (main empty, skid empty).
  - FULL (main occupied, skid empty).
  - SKID (main and skid both occupied).
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY:
  - accept: main<=in, go to FULL.
  - otherwise stay.
- FULL:
  - accept & drain: main<=in, stay FULL.
  - accept & !drain: skid<=in, go to SKID.
  - !accept & drain: go to EMPTY; main ctrl<=CTRL_BUBBLE.
  - otherwise hold.
- SKID:
  - drain: main<=skid, go to FULL.
  - otherwise hold.
- in_ready:
  - Registered; equals (next_state != SKID).
  - in_valid is never consumed in SKID.
- Flush:
  - Next state=EMPTY, regardless of in_valid/out_ready.
  - Main and skid ctrl<=CTRL_BUBBLE; data not cleared; in_ready<=1.
  - An entry presented in the flush cycle is dropped, even if in_ready=1.
  - A drain in the flush cycle still counts as completed downstream.
- Timing:
  - Latency is 1 cycle from accept to out_valid when the stage is empty.
  - Sustained throughput is 1 entry per cycle with out_ready=1.
  - Ordering is strictly FIFO.
- Data flops are updated only on load; ctrl flops are updated on load or bubble. This keeps toggling low.

Optional Feature:
- Macro: PIPE_STAGE_STAT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready & !flush.
  - flush_cnt increments each cycle flush=1 while state!=EMPTY.
  - Both are 32-bit, saturating at 0xFFFFFFFF, and reset to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - the state enum (EMPTY=2'b00, FULL=2'b01, SKID=2'b10);
  - ctrl bit-position constants (CTRL_RF_WE, CTRL_DRAM_WE, CTRL_PC_SEL, CTRL_WD_SEL, CTRL_ALU_OP);
  - per-stage CTRL_W/DATA_W constants.
- One sub-module, pipe_stage_stat, holds the saturating counters and is instantiated only under the macro.

Test Plan:
- Single entry: reset; drive in_valid=1, ctrl=16'h0003, data=128'hA5 for 1 cycle with out_ready=1 -> next cycle out_valid=1, out_ctrl=16'h0003, out_data=A5; the cycle after, out_valid=0 and out_ctrl=0.
- Streaming: stream 8 entries (data=1..8) back-to-back with out_ready=1 -> out_data=1..8 on consecutive cycles and in_ready stays 1.
- Backpressure: out_ready=0 while sending 1,2,3 -> entries 1 and 2 are accepted and in_ready falls to 0 after the 2nd; then set out_ready=1 -> outputs 1,2,3 in order with no loss or duplication.
- Flush: in SKID holding entries 5 and 6, assert flush with in_valid=1 carrying 7 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1; entries 5, 6 and 7 never appear.
- Async reset: assert rst_n=0 mid-cycle while FULL -> out_valid=0 and out_ctrl=0 immediately, before the next clk edge.
- Stats (PIPE_STAGE_STAT_EN defined): hold out_ready=0 with a valid entry for 10 cycles, then flush once -> stall_cnt=10, flush_cnt=1.
